vga_timing_gen: RTL and testbench

// - Consumes the slow toggling VGA_clock from the clock divider and produces VGA raster timing.
// - Outputs are sync pulses, blanking and pixel coordinates that drive the Pacman renderer and the VGA DAC pins.
// - Runs entirely in the CLOCK_50 domain.
// - Each rising edge of VGA_clock advances the raster by one pixel.

---
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: edge-detects the divided VGA_clock and walks an 800x525 raster in the CLOCK_50 domain.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame_count port that advances on every frame_start.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CNT_W    = 10
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic             VGA_clock,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic             VGA_BLANK_N,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             line_start,
   output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [7:0]       frame_count
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

   logic             clk_q_reg;
   logic [CNT_W-1:0] h_reg, h_next;
   logic [CNT_W-1:0] v_reg, v_next;
   logic             hs_reg, hs_next;
   logic             vs_reg, vs_next;
   logic             blank_n_reg, blank_n_next;
   logic             line_start_reg, line_start_next;
   logic             frame_start_reg, frame_start_next;
   logic             tick, h_wrap, v_wrap;

   assign tick   = VGA_clock & ~clk_q_reg;
   assign h_wrap = tick && (h_reg == H_LAST);
   assign v_wrap = h_wrap && (v_reg == V_LAST);

   // Outputs are decoded from the next counts so they move on the same edge as the counters.
   always_comb begin
      h_next = h_reg;
      v_next = v_reg;
      if (tick) begin
         if (h_wrap) begin
            h_next = CNT_ZERO;
            v_next = v_wrap ? CNT_ZERO : v_reg + CNT_ONE;
         end else begin
            h_next = h_reg + CNT_ONE;
         end
      end
      hs_next          = !((h_next >= HS_START) && (h_next < HS_END));
      vs_next          = !((v_next >= VS_START) && (v_next < VS_END));
      blank_n_next     = (h_next < H_ACT_C) && (v_next < V_ACT_C);
      line_start_next  = h_wrap;
      frame_start_next = v_wrap;
   end

   // clk_q loads VGA_clock during reset so a level already high at release is not seen as an edge.
   always_ff @(posedge CLOCK_50) begin
      clk_q_reg <= VGA_clock;
      if (!resetn) begin
         h_reg           <= CNT_ZERO;
         v_reg           <= CNT_ZERO;
         hs_reg          <= 1'b1;
         vs_reg          <= 1'b1;
         blank_n_reg     <= 1'b1;
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         h_reg           <= h_next;
         v_reg           <= v_next;
         hs_reg          <= hs_next;
         vs_reg          <= vs_next;
         blank_n_reg     <= blank_n_next;
         line_start_reg  <= line_start_next;
         frame_start_reg <= frame_start_next;
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] frame_count_reg;

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         frame_count_reg <= 8'd0;
      end else if (frame_start_next) begin
         frame_count_reg <= frame_count_reg + 8'd1;
      end
   end

   assign frame_count = frame_count_reg;
`endif

   assign VGA_HS      = hs_reg;
   assign VGA_VS      = vs_reg;
   assign VGA_BLANK_N = blank_n_reg;
   assign pixel_x     = h_reg;
   assign pixel_y     = v_reg;
   assign line_start  = line_start_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size instance for horizontal timing and a shrunken
// instance (16x12 raster) so vertical sync and frame wrap are reachable in a short run.
module tb_vga_timing_gen;

   logic       CLOCK_50;
   logic       resetn;
   logic       VGA_clock;

   logic       d_hs, d_vs, d_blank_n, d_ls, d_fs;
   logic [9:0] d_x, d_y;
   logic       s_hs, s_vs, s_blank_n, s_ls, s_fs;
   logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] d_fc, s_fc;
`endif

   vga_timing_gen dut (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .VGA_clock  (VGA_clock),
      .VGA_HS     (d_hs),
      .VGA_VS     (d_vs),
      .VGA_BLANK_N(d_blank_n),
      .pixel_x    (d_x),
      .pixel_y    (d_y),
      .line_start (d_ls),
      .frame_start(d_fs)
`ifdef VGA_FRAME_COUNT_EN
      ,
      .frame_count(d_fc)
`endif
   );

   // Small raster: H 8+2+3+3 = 16, V 6+2+2+2 = 12; VS low on lines 8..9.
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .CNT_W(10)
   ) dut_s (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .VGA_clock  (VGA_clock),
      .VGA_HS     (s_hs),
      .VGA_VS     (s_vs),
      .VGA_BLANK_N(s_blank_n),
      .pixel_x    (s_x),
      .pixel_y    (s_y),
      .line_start (s_ls),
      .frame_start(s_fs)
`ifdef VGA_FRAME_COUNT_EN
      ,
      .frame_count(s_fc)
`endif
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic expect_val(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
      end
   endtask

   // One full VGA_clock period; outputs are sampled on negedges only.
   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) begin
         VGA_clock = 1'b1;
         @(negedge CLOCK_50);
         VGA_clock = 1'b0;
         @(negedge CLOCK_50);
      end
   endtask

   task automatic expect_reset_state(input string who);
      expect_val({who, "_x"}, 0);
      expect_val({who, "_y"}, 0);
      expect_val({who, "_hs"}, 1);
      expect_val({who, "_vs"}, 1);
      expect_val({who, "_blank_n"}, 1);
      expect_val({who, "_line_start"}, 0);
      expect_val({who, "_frame_start"}, 0);
   endtask

   task automatic check_d_state();
      pop_check(32'(d_x)); pop_check(32'(d_y)); pop_check(32'(d_hs)); pop_check(32'(d_vs));
      pop_check(32'(d_blank_n)); pop_check(32'(d_ls)); pop_check(32'(d_fs));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn    = 1'b0;
      VGA_clock = 1'b1;
      repeat (5) @(negedge CLOCK_50);
      resetn = 1'b1;

      // Release with VGA_clock already high: no tick may be seen.
      expect_reset_state("rst_release");
      @(negedge CLOCK_50);
      check_d_state();
      $display("reset release: x=%0d y=%0d", d_x, d_y);
`ifdef VGA_FRAME_COUNT_EN
      expect_val("rst_frame_count", 0);
      pop_check(32'(d_fc));
`endif
      expect_val("no_tick_after_release_x", 0);
      @(negedge CLOCK_50);
      pop_check(32'(d_x));
      VGA_clock = 1'b0;
      @(negedge CLOCK_50);

      // Long high level: a single increment, visible one cycle after the rise.
      expect_val("hold_first_x", 1);
      VGA_clock = 1'b1;
      @(negedge CLOCK_50);
      pop_check(32'(d_x));
      expect_val("hold_50_x", 1);
      repeat (49) @(negedge CLOCK_50);
      pop_check(32'(d_x));
      expect_val("fall_ignored_x", 1);
      VGA_clock = 1'b0;
      @(negedge CLOCK_50);
      pop_check(32'(d_x));
      $display("hold high: x=%0d", d_x);

      expect_val("toggle_x", 4);
      ticks(3);
      pop_check(32'(d_x));

      // Horizontal boundaries on the full-size instance (tick count n).
      expect_val("n639_blank_n", 1);
      ticks(635);
      pop_check(32'(d_blank_n));
      expect_val("n640_blank_n", 0);
      expect_val("n640_x", 640);
      ticks(1);
      pop_check(32'(d_blank_n)); pop_check(32'(d_x));
      expect_val("n655_hs", 1);
      ticks(15);
      pop_check(32'(d_hs));
      expect_val("n656_hs", 0);
      expect_val("n656_x", 656);
      ticks(1);
      pop_check(32'(d_hs)); pop_check(32'(d_x));
      expect_val("n751_hs", 0);
      ticks(95);
      pop_check(32'(d_hs));
      expect_val("n752_hs", 1);
      ticks(1);
      pop_check(32'(d_hs));
      $display("hsync window checked at x=%0d", d_x);

      // Line wrap at 800 ticks.
      ticks(47);
      expect_val("n800_x", 0);
      expect_val("n800_y", 1);
      expect_val("n800_line_start", 1);
      expect_val("n800_frame_start", 0);
      VGA_clock = 1'b1;
      @(negedge CLOCK_50);
      pop_check(32'(d_x)); pop_check(32'(d_y)); pop_check(32'(d_ls)); pop_check(32'(d_fs));
      expect_val("n800_line_start_drop", 0);
      expect_val("n800_blank_n", 1);
      VGA_clock = 1'b0;
      @(negedge CLOCK_50);
      pop_check(32'(d_ls)); pop_check(32'(d_blank_n));
      $display("line wrap: x=%0d y=%0d", d_x, d_y);

      // Reset coinciding with the tick that would make x=300.
      ticks(299);
      expect_val("pre_reset_x", 299);
      expect_val("pre_reset_y", 1);
      pop_check(32'(d_x)); pop_check(32'(d_y));
      expect_reset_state("mid_reset");
      expect_val("mid_reset_small_x", 0);
      VGA_clock = 1'b1;
      resetn    = 1'b0;
      @(negedge CLOCK_50);
      check_d_state();
      pop_check(32'(s_x));
      resetn    = 1'b1;
      VGA_clock = 1'b0;
      expect_val("post_reset_x", 0);
      @(negedge CLOCK_50);
      pop_check(32'(d_x));
      $display("mid-frame reset: x=%0d y=%0d", d_x, d_y);

      // Vertical timing and frame wrap on the small instance (16 ticks per line).
      expect_val("s_n127_vs", 1);
      ticks(127);
      pop_check(32'(s_vs));
      expect_val("s_n128_vs", 0);
      expect_val("s_n128_y", 8);
      ticks(1);
      pop_check(32'(s_vs)); pop_check(32'(s_y));
      expect_val("s_n159_vs", 0);
      ticks(31);
      pop_check(32'(s_vs));
      expect_val("s_n160_vs", 1);
      ticks(1);
      pop_check(32'(s_vs));
      expect_val("s_n170_hs", 0);
      expect_val("s_n170_blank_n", 0);
      ticks(10);
      pop_check(32'(s_hs)); pop_check(32'(s_blank_n));
      ticks(21);
      expect_val("s_n191_frame_start", 0);
      pop_check(32'(s_fs));
      expect_val("s_n192_x", 0);
      expect_val("s_n192_y", 0);
      expect_val("s_n192_frame_start", 1);
      expect_val("s_n192_line_start", 1);
`ifdef VGA_FRAME_COUNT_EN
      expect_val("s_n192_frame_count", 1);
`endif
      VGA_clock = 1'b1;
      @(negedge CLOCK_50);
      pop_check(32'(s_x)); pop_check(32'(s_y)); pop_check(32'(s_fs)); pop_check(32'(s_ls));
`ifdef VGA_FRAME_COUNT_EN
      pop_check(32'(s_fc));
`endif
      expect_val("s_n192_frame_start_drop", 0);
      VGA_clock = 1'b0;
      @(negedge CLOCK_50);
      pop_check(32'(s_fs));
      $display("small frame wrap: x=%0d y=%0d", s_x, s_y);

      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_leftover: observed %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
